// File: rtl/posit_regime_scanner_if.sv
// Operand/result bundle between the operand registers, the regime scanner
// and the exponent/fraction extract stage. Two valid/ready handshakes:
// In* carries raw posits in, Out* carries decoded regime results out.
interface posit_regime_scanner_if #(
    parameter int N  = 32,
    parameter int RS = $clog2(N)
);
    logic         InValid;
    logic         InReady;
    logic [N-1:0] In;
    logic         OutValid;
    logic         OutReady;
    logic         Sign;
    logic [RS:0]  RunLength;
    logic [RS:0]  RegimeK;
    logic [N-2:0] Remainder;
    logic         IsZero;
    logic         IsNaR;

    // Scanner view: consumes operands, produces decoded results.
    modport slave (
        input  InValid, In, OutReady,
        output InReady, OutValid, Sign, RunLength, RegimeK, Remainder, IsZero, IsNaR
    );

    // Producer/consumer view: supplies operands, takes results.
    modport master (
        output InValid, In, OutReady,
        input  InReady, OutValid, Sign, RunLength, RegimeK, Remainder, IsZero, IsNaR
    );
endinterface

// File: rtl/posit_regime_scanner.sv
// Iterative posit regime scanner. Accepts a raw N-bit posit, resolves the
// sign (two's-complementing negative operands), then walks the regime run
// SEG bits per cycle from the MSB. Reports run length, signed regime k and
// the exponent/fraction remainder left-aligned.
//
// Optional feature macro: POSIT_SPECIAL_DETECT_EN
//   defined   - zero and NaR are flagged on accept and skip the scan.
//   undefined - IsZero/IsNaR tie low; zero and NaR scan as all-zero bodies.
module posit_regime_scanner #(
    parameter int N   = 32,
    parameter int ES  = 2,
    parameter int SEG = 4,
    parameter int RS  = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  reset,
    posit_regime_scanner_if.slave bus
);
    // ES is only carried for the downstream extract stage; it joins the
    // legality check so an inconsistent parameter set fails elaboration.
    if (N < 4 || SEG < 1 || SEG > N - 1 || ES < 0) begin : g_param_check
        $error("posit_regime_scanner: illegal N/SEG/ES combination");
    end

    localparam logic [RS:0]  RUN_ONE  = (RS+1)'(1);
    localparam logic [RS:0]  BODY_LEN = (RS+1)'(N - 1);
    localparam logic [N-2:0] BODY_ONE = (N-1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [N-2:0] body_q,  body_d;
    logic         sign_q,  sign_d;
    logic         rc_q,    rc_d;
    logic [RS:0]  run_q,   run_d;
`ifdef POSIT_SPECIAL_DETECT_EN
    logic         iszero_q, iszero_d;
    logic         isnar_q,  isnar_d;
`endif

    logic [N-2:0] body_in;
    logic [RS:0]  seg_cnt;
    logic         seg_term;
    logic [RS:0]  rem_shift;

    // Magnitude body: the low N-1 bits of the two's complement equal the
    // two's complement of the low N-1 bits, so the sign bit never enters.
    assign body_in = bus.In[N-1] ? (~bus.In[N-2:0] + BODY_ONE) : bus.In[N-2:0];

    // Count leading RC bits in the current segment. Bits above run_q were
    // already consumed; the window is clipped at the end of the body.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the block can leave a latch behind.
        seg_cnt  = '0;
        seg_term = 1'b0;
        for (int p = 0; p < N - 1; p++) begin
            if (!seg_term && p >= int'(run_q) && p < int'(run_q) + SEG) begin
                if (body_q[N-2-p] == rc_q) begin
                    seg_cnt = seg_cnt + RUN_ONE;
                end else begin
                    seg_term = 1'b1;
                end
            end
        end
    end

    // Next-state and next-operand logic for the IDLE -> SCAN -> DONE loop.
    always_comb begin
        state_d  = state_q;
        body_d   = body_q;
        sign_d   = sign_q;
        rc_d     = rc_q;
        run_d    = run_q;
`ifdef POSIT_SPECIAL_DETECT_EN
        iszero_d = iszero_q;
        isnar_d  = isnar_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.InValid) begin
                    body_d  = body_in;
                    sign_d  = bus.In[N-1];
                    rc_d    = body_in[N-2];
                    run_d   = '0;
                    state_d = SCAN;
`ifdef POSIT_SPECIAL_DETECT_EN
                    // Zero and NaR both have an all-zero body with RC=0, so
                    // run=0 already yields RegimeK=0 and Remainder=0.
                    iszero_d = (bus.In == '0);
                    isnar_d  = (bus.In == {1'b1, {(N-1){1'b0}}});
                    if (iszero_d || isnar_d) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            SCAN: begin
                run_d = run_q + seg_cnt;
                if (seg_term || run_d == BODY_LEN) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.OutReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and operand registers; reset clears everything so outputs read 0.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= IDLE;
            body_q   <= '0;
            sign_q   <= 1'b0;
            rc_q     <= 1'b0;
            run_q    <= '0;
`ifdef POSIT_SPECIAL_DETECT_EN
            iszero_q <= 1'b0;
            isnar_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            body_q   <= body_d;
            sign_q   <= sign_d;
            rc_q     <= rc_d;
            run_q    <= run_d;
`ifdef POSIT_SPECIAL_DETECT_EN
            iszero_q <= iszero_d;
            isnar_q  <= isnar_d;
`endif
        end
    end

    // Shifting out the run plus its terminator leaves exponent/fraction
    // left-aligned; a run of N-1 shifts everything out.
    assign rem_shift = run_q + RUN_ONE;

    assign bus.InReady   = (state_q == IDLE);
    assign bus.OutValid  = (state_q == DONE);
    assign bus.Sign      = sign_q;
    assign bus.RunLength = run_q;
    assign bus.RegimeK   = rc_q ? (run_q - RUN_ONE) : (-run_q);
    assign bus.Remainder = body_q << rem_shift;
`ifdef POSIT_SPECIAL_DETECT_EN
    assign bus.IsZero    = iszero_q;
    assign bus.IsNaR     = isnar_q;
`else
    assign bus.IsZero    = 1'b0;
    assign bus.IsNaR     = 1'b0;
`endif
endmodule

// File: tb/tb_posit_regime_scanner.sv
// Directed bench for posit_regime_scanner at N=8, ES=2, SEG=2. Expected
// results are queued when an operand is driven and compared when the
// scanner presents OutValid.
module tb_posit_regime_scanner;
    localparam int N   = 8;
    localparam int ES  = 2;
    localparam int SEG = 2;
    localparam int RS  = 3;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    posit_regime_scanner_if #(.N(N), .RS(RS)) bus ();

    posit_regime_scanner #(.N(N), .ES(ES), .SEG(SEG), .RS(RS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic         sign;
        logic [RS:0]  run;
        logic [RS:0]  k;
        logic [N-2:0] rem;
        logic         zero;
        logic         nar;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic s, input int run, input int k, input logic [N-2:0] rem,
                            input logic z, input logic n, input int lat);
        exp_t e;
        e.sign = s;
        e.run  = (RS+1)'(run);
        e.k    = (RS+1)'(k);
        e.rem  = rem;
        e.zero = z;
        e.nar  = n;
        e.lat  = lat;
        sb_q.push_back(e);
    endtask

    // Entered and left at a negedge; the accept happens at the posedge between.
    task automatic drive_op(input string tag, input logic [N-1:0] val);
        int waited = 0;
        while (!bus.InReady && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_inready"}, bus.InReady, 1);
        bus.In      = val;
        bus.InValid = 1'b1;
        @(negedge clk);
        bus.InValid = 1'b0;
    endtask

    // Called at the first negedge after the accept edge (cycle 1 after accept).
    task automatic wait_result(input string tag);
        int   cyc = 1;
        exp_t e;
        while (!bus.OutValid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_outvalid"}, bus.OutValid, 1);
        check({tag, "_sb_pending"}, sb_q.size() > 0, 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_latency"}, cyc, e.lat);
            check({tag, "_sign"}, bus.Sign, e.sign);
            check({tag, "_run"}, bus.RunLength, e.run);
            check({tag, "_k"}, bus.RegimeK, e.k);
            check({tag, "_rem"}, bus.Remainder, e.rem);
            check({tag, "_iszero"}, bus.IsZero, e.zero);
            check({tag, "_isnar"}, bus.IsNaR, e.nar);
        end
    endtask

    // Let the result go and confirm the scanner is back in IDLE.
    task automatic handoff(input string tag);
        bus.OutReady = 1'b1;
        @(negedge clk);
        check({tag, "_back_idle_inready"}, bus.InReady, 1);
        check({tag, "_back_idle_outvalid"}, bus.OutValid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen_valid;

        reset        = 1'b1;
        bus.InValid  = 1'b0;
        bus.In       = '0;
        bus.OutReady = 1'b1;
        repeat (2) @(negedge clk);

        check("reset_inready", bus.InReady, 1);
        check("reset_outvalid", bus.OutValid, 0);
        check("reset_sign", bus.Sign, 0);
        check("reset_run", bus.RunLength, 0);
        check("reset_k", bus.RegimeK, 0);
        check("reset_rem", bus.Remainder, 0);
        check("reset_iszero", bus.IsZero, 0);
        check("reset_isnar", bus.IsNaR, 0);
        reset = 1'b0;
        @(negedge clk);

        // Positive operand, regime of two ones.
        push_exp(1'b0, 2, 1, 7'b1101000, 1'b0, 1'b0, 3);
        drive_op("pos_6d", 8'b0110_1101);
        wait_result("pos_6d");
        handoff("pos_6d");

        // Negative operand whose two's complement is 0110_1101.
        push_exp(1'b1, 2, 1, 7'b1101000, 1'b0, 1'b0, 3);
        drive_op("neg_93", 8'b1001_0011);
        wait_result("neg_93");
        handoff("neg_93");

        // Long zero run ending on the last truncated segment.
        push_exp(1'b0, 6, -6, 7'b0000000, 1'b0, 1'b0, 5);
        drive_op("run6_01", 8'b0000_0001);
        wait_result("run6_01");
        handoff("run6_01");

        // No terminator: all body bits consumed.
        push_exp(1'b0, 7, 6, 7'b0000000, 1'b0, 1'b0, 5);
        drive_op("run7_7f", 8'b0111_1111);
        wait_result("run7_7f");
        handoff("run7_7f");

        // Single-zero run, terminator inside the first segment.
        push_exp(1'b0, 1, -1, 7'b0101100, 1'b0, 1'b0, 2);
        drive_op("run1_2b", 8'b0010_1011);
        wait_result("run1_2b");
        handoff("run1_2b");

        // Backpressure: result held for five cycles while a new operand waits.
        bus.OutReady = 1'b0;
        push_exp(1'b0, 2, 1, 7'b1101000, 1'b0, 1'b0, 3);
        drive_op("bp", 8'b0110_1101);
        wait_result("bp");
        bus.In      = 8'b0000_0001;
        bus.InValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", {bus.OutValid, bus.InReady, bus.Sign, bus.RunLength, bus.RegimeK, bus.Remainder},
                  {1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 7'b1101000});
        end
        bus.OutReady = 1'b1;
        push_exp(1'b0, 6, -6, 7'b0000000, 1'b0, 1'b0, 5);
        @(negedge clk);
        check("bp_idle_inready", bus.InReady, 1);
        check("bp_idle_outvalid", bus.OutValid, 0);
        @(negedge clk);
        bus.InValid = 1'b0;
        wait_result("bp_next");
        handoff("bp_next");

        // Reset during the second scan cycle discards the operand.
        drive_op("rst_mid", 8'b0000_0001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_inready", bus.InReady, 1);
        check("rst_mid_outvalid", bus.OutValid, 0);
        check("rst_mid_sign", bus.Sign, 0);
        check("rst_mid_run", bus.RunLength, 0);
        check("rst_mid_k", bus.RegimeK, 0);
        check("rst_mid_rem", bus.Remainder, 0);
        reset      = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            seen_valid = seen_valid | bus.OutValid;
        end
        check("rst_mid_no_result", seen_valid, 0);

        // Zero and NaR operands.
`ifdef POSIT_SPECIAL_DETECT_EN
        push_exp(1'b0, 0, 0, 7'b0000000, 1'b1, 1'b0, 1);
        drive_op("zero_00", 8'h00);
        wait_result("zero_00");
        handoff("zero_00");
        push_exp(1'b1, 0, 0, 7'b0000000, 1'b0, 1'b1, 1);
        drive_op("nar_80", 8'h80);
        wait_result("nar_80");
        handoff("nar_80");
`else
        push_exp(1'b0, 7, -7, 7'b0000000, 1'b0, 1'b0, 5);
        drive_op("zero_00", 8'h00);
        wait_result("zero_00");
        handoff("zero_00");
        push_exp(1'b1, 7, -7, 7'b0000000, 1'b0, 1'b0, 5);
        drive_op("nar_80", 8'h80);
        wait_result("nar_80");
        handoff("nar_80");
`endif

        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/posit_regime_scanner.md
Name: posit_regime_scanner

Overview:
- Iterative, parametrised successor to the combinational leading-bit detector in the posit arithmetic path.
- Accepts a raw N-bit posit and resolves sign; conditionally two's-complements the operand.
- Scans the regime run SEG bits per cycle from the MSB. Returns run length, signed regime value k, and the exponent/fraction remainder left-aligned.
- Sits between the operand registers and the exponent/fraction extract stage, with valid/ready handshakes on both sides.

Parameters:
- N, 32, posit width in bits (N ≥ 4)
- ES, 2, exponent field width; passed through to downstream, not used internally
- SEG, 4, bits examined per scan cycle (1 ≤ SEG ≤ N-1)
- RS, $clog2(N), width base for run and k outputs

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- InValid  in  1  operand valid
- InReady  out  1  block can accept an operand
- In  in  N  raw posit
- OutValid  out  1  result valid
- OutReady  in  1  consumer accepts result
- Sign  out  1  In[N-1] of the accepted operand
- RunLength  out  RS+1  unsigned count of regime bits equal to RC (1..N-1)
- RegimeK  out  RS+1  signed k
- Remainder  out  N-1  body shifted left by RunLength+1, zero-filled
- IsZero  out  1  operand is zero (feature-dependent)
- IsNaR  out  1  operand is NaR (feature-dependent)

Behaviour:
- Clock and reset: one clock, `clk`. Reset `reset` is synchronous and active-high.
- Reset values: state=IDLE, InReady=1, OutValid=0. All data outputs are 0.
- State machine IDLE → SCAN → DONE → IDLE.
- IDLE:
  - InReady=1.
  - On InValid&&InReady, register body = In[N-1] ? (two's complement of In)[N-2:0] : In[N-2:0].
  - Register Sign=In[N-1] and RC=body[N-2]. Clear the run counter and go to SCAN.
- SCAN:
  - InReady=0.
  - Each cycle examines the next SEG body bits from the MSB. The last segment is truncated to the bits remaining.
  - The run counter adds the number of leading bits equal to RC in that segment.
  - If a bit differs from RC (the terminator) or all N-1 bits are consumed, go to DONE.
  - Scan cycles = min(floor(RunLength/SEG)+1, ceil((N-1)/SEG)).
- DONE:
  - OutValid=1. Outputs stay stable while OutValid && !OutReady.
  - On OutReady, go to IDLE with InReady=1 in the following cycle. There is no accept in the same cycle as the handoff.
- Latency: accept cycle + scan cycles + 1 cycle to OutValid.
- RegimeK = RC ? RunLength-1 : -RunLength, sign-extended to RS+1 bits.
- Remainder = (body << (RunLength+1)) truncated to N-1 bits. It is 0 when RunLength = N-1 (no terminator).
- Reset asserted in any state returns to IDLE next edge. An in-flight operand is discarded and OutValid drops.
- InValid while InReady=0 is ignored. The producer holds In/InValid.

Optional Feature:
- Macro: POSIT_SPECIAL_DETECT_EN.
- When defined:
  - On accept, In==0 sets IsZero; In=={1'b1,{N-1{1'b0}}} sets IsNaR.
  - Special operands bypass SCAN: IDLE → DONE, so OutValid is high the cycle after accept.
  - For specials, RunLength=0, RegimeK=0, Remainder=0.
- When undefined:
  - IsZero and IsNaR are tied 0.
  - Zero and NaR scan as ordinary operands, giving an all-zero body: RunLength=N-1, RegimeK=-(N-1).

Test Plan (N=8, ES=2, SEG=2):
- In=8'b0110_1101, OutReady=1 → Sign=0, RunLength=2, RegimeK=1, Remainder=7'b1101000; 2 scan cycles; OutValid 3 cycles after accept.
- In=8'b1001_0011 → two's complement 0110_1101 → Sign=1, RunLength=2, RegimeK=1, Remainder=7'b1101000.
- In=8'b0000_0001 → RunLength=6, RegimeK=-6, Remainder=0; 4 scan cycles. In=8'b0111_1111 → RunLength=7, RegimeK=6, Remainder=0; 4 scan cycles.
- Backpressure: hold OutReady=0 for 5 cycles in DONE → outputs stable, InReady=0 with InValid=1 (no accept); after OutReady=1, IDLE then next operand accepted.
- Assert reset during the 2nd SCAN cycle of In=8'b0000_0001 → next cycle IDLE, OutValid=0, InReady=1, outputs 0; no result emitted.
- In=8'h00 and In=8'h80:
  - With POSIT_SPECIAL_DETECT_EN defined: IsZero=1 / IsNaR=1, OutValid 1 cycle after accept.
  - Without the macro: 8'h00 → RunLength=7, RegimeK=-7, Sign=0; 8'h80 → same values with Sign=1.
